// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 3-bit op codes for ALUControl
//   - FSM state type for alu_seq
//   - flag record and the flag computation used for both single-cycle and MUL results
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
        logic carry;
    } alu_flags_t;

    // Width-agnostic: takes only the sign bits and summary bits it needs.
    function automatic alu_flags_t calc_flags(
        input logic [2:0] op,
        input logic       a_msb,
        input logic       b_msb,
        input logic       res_msb,
        input logic       res_zero,
        input logic       carry_out,
        input logic       mul_hi_nz
    );
        alu_flags_t f;
        f.zero     = res_zero;
        f.negative = res_msb;
        f.overflow = 1'b0;
        f.carry    = 1'b0;
        case (op)
            OP_ADD: begin
                f.carry    = carry_out;
                f.overflow = (a_msb == b_msb) && (res_msb != a_msb);
            end
            OP_SUB: begin
                // carry_out of A + ~B + 1 is the no-borrow indication
                f.carry    = carry_out;
                f.overflow = (a_msb != b_msb) && (res_msb != a_msb);
            end
            OP_MUL: f.overflow = mul_hi_nz;
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one step per cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             latch a/b and begin (ignored unless the caller is idle)
//   a, b              WIDTH-bit unsigned operands
//   done              high during the final step cycle; product is valid then
//   product           2*WIDTH-bit product (combinational next accumulator value)
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Exposing acc_next lets the caller load the product on the last step edge.
    assign product = acc_next;
    assign done    = busy && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
// Single-cycle ops load the output register on the accept edge; MUL runs
// WIDTH shift-add steps in alu_mul_iter and loads on the last step edge.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid / in_ready            operand handshake
//   SrcA, SrcB, ALUControl         operands and op select
//   out_valid / out_ready          result handshake
//   ALUResult, Zero, Negative,     registered result and flags
//   Overflow, Carry
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             Carry
);
    localparam int unsigned SHW = $clog2(WIDTH);

    state_t             state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;
    alu_flags_t         op_flags;
    alu_flags_t         mul_flags;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (ALUControl == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (SrcA),
        .b       (SrcB),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        add_ext  = {1'b0, SrcA} + {1'b0, SrcB};
        sub_ext  = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        op_res   = '0;
        op_carry = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                op_res   = add_ext[WIDTH-1:0];
                op_carry = add_ext[WIDTH];
            end
            OP_SUB: begin
                op_res   = sub_ext[WIDTH-1:0];
                op_carry = sub_ext[WIDTH];
            end
            OP_AND: op_res = SrcA & SrcB;
            OP_OR:  op_res = SrcA | SrcB;
            OP_XOR: op_res = SrcA ^ SrcB;
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLL: op_res = SrcA << SrcB[SHW-1:0];
            default: op_res = '0;
        endcase
        op_flags  = calc_flags(ALUControl, SrcA[WIDTH-1], SrcB[WIDTH-1],
                               op_res[WIDTH-1], (op_res == '0), op_carry, 1'b0);
        // ALUControl may have moved on during BUSY, so the op is fixed here.
        mul_flags = calc_flags(OP_MUL, 1'b0, 1'b0, mul_product[WIDTH-1],
                               (mul_product[WIDTH-1:0] == '0), 1'b0,
                               |mul_product[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Overflow  <= 1'b0;
            Carry     <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ALUControl == OP_MUL) begin
                            state <= BUSY;
                        end else begin
                            out_valid <= 1'b1;
                            ALUResult <= op_res;
                            Zero      <= op_flags.zero;
                            Negative  <= op_flags.negative;
                            Overflow  <= op_flags.overflow;
                            Carry     <= op_flags.carry;
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        ALUResult <= mul_product[WIDTH-1:0];
                        Zero      <= mul_flags.zero;
                        Negative  <= mul_flags.negative;
                        Overflow  <= mul_flags.overflow;
                        Carry     <= mul_flags.carry;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8).
module tb_alu_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic [2:0]  ALUControl;
    logic        Zero, Negative, Overflow, Carry;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  SrcA8, SrcB8, ALUResult8;
    logic [2:0]  ALUControl8;
    logic        Zero8, Negative8, Overflow8, Carry8;

    int unsigned n_checks;
    int unsigned n_errors;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult),
        .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .SrcA(SrcA8), .SrcB(SrcB8), .ALUControl(ALUControl8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .ALUResult(ALUResult8),
        .Zero(Zero8), .Negative(Negative8), .Overflow(Overflow8), .Carry(Carry8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags32();
        return {Zero, Negative, Overflow, Carry};
    endfunction

    // Issue one single-cycle op, check result one edge after accept.
    task automatic op32(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        SrcA = a; SrcB = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"},   64'(ALUResult), 64'(er));
        check({tag, "_flags"}, 64'(flags32()), 64'(ef));
    endtask

    task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef);
        int unsigned cycles;
        logic        busy_bad;
        SrcA = a; SrcB = b; ALUControl = 3'b111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        busy_bad = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_latency"},  64'(cycles), 64'd32);
        check({tag, "_busy_rdy"}, 64'(busy_bad), 64'd0);
        check({tag, "_res"},      64'(ALUResult), 64'(er));
        check({tag, "_flags"},    64'(flags32()), 64'(ef));
    endtask

    initial begin
        int unsigned cycles;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; SrcA = '0; SrcB = '0; ALUControl = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; SrcA8 = '0; SrcB8 = '0; ALUControl8 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res",   64'(ALUResult), 64'd0);
        check("rst_flags", 64'(flags32()), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("pre_add_valid", 64'(out_valid), 64'd0);

        //             tag     op     A             B             result        ZNVC
        op32("add",   3'b000, 32'd5,        32'd4,        32'd9,        4'b0000);
        op32("sub_p", 3'b001, 32'd5,        32'd4,        32'd1,        4'b0001);
        op32("sub_n", 3'b001, 32'd4,        32'd5,        32'hFFFFFFFF, 4'b0100);
        op32("add_v", 3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110);
        op32("add_c", 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001);
        op32("and",   3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
        op32("or_z",  3'b011, 32'd0,        32'd0,        32'd0,        4'b1000);
        op32("sll",   3'b110, 32'd1,        32'd31,       32'h80000000, 4'b0100);
        op32("slt_t", 3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b0000);
        op32("slt_f", 3'b101, 32'd1,        32'hFFFFFFFF, 32'd0,        4'b1000);
        op32("xor",   3'b100, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000);

        // Backpressure: stall the consumer while a second op waits upstream.
        SrcA = 32'd10; SrcB = 32'd20; ALUControl = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_first_res", 64'(ALUResult), 64'd30);
        SrcA = 32'd9; SrcB = 32'd3; ALUControl = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_res",   64'(ALUResult), 64'd30);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_rdy",   64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_res",   64'(ALUResult), 64'd6);
        check("bp_second_flags", 64'(flags32()), 64'd1);

        mul32("mul_big", 32'h00010000, 32'h00010000, 32'd0,  4'b1010);
        mul32("mul_3x7", 32'd3,        32'd7,        32'd21, 4'b0000);

        // Reset in the middle of a MUL, with a nonzero result already registered.
        op32("xor_pre", 3'b100, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000);
        SrcA = 32'd3; SrcB = 32'd7; ALUControl = 3'b111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_res",   64'(ALUResult), 64'd0);
        check("mid_rst_flags", 64'(flags32()), 64'd0);
        check("mid_rst_rdy",   64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op32("add_post", 3'b000, 32'd2, 32'd2, 32'd4, 4'b0000);

        // WIDTH=8 instance: 10 x 10 = 0x64 in 8 cycles.
        SrcA8 = 8'd10; SrcB8 = 8'd10; ALUControl8 = 3'b111; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        cycles = 0;
        while (!out_valid8 && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("w8_mul_latency", 64'(cycles), 64'd8);
        check("w8_mul_res",     64'(ALUResult8), 64'h64);
        check("w8_mul_flags",   64'({Zero8, Negative8, Overflow8, Carry8}), 64'd0);
        op32("add_tail", 3'b000, 32'd1, 32'd1, 32'd2, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
